r2sdf_frame_sequencer: RTL

Frame-level controller for the radix-2 single-path delay-feedback (R2SDF) FFT pipeline.
- Input side: accepts a complex sample stream through a valid/ready handshake, counts `2^N`-sample frames, drives the first butterfly stage's data input and one-cycle `start_ip` pulse, and zero-fills and flags underruns.
- Output side: watches the last stage's `start_op` pulse and frames the result stream with valid/last/frame-id qualifiers.

---
 rtl/r2sdf_frame_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/r2sdf_frame_sequencer.sv
// r2sdf_frame_sequencer: frame-level controller for an R2SDF FFT pipeline.
// Input side feeds 2^N-sample frames into stage 1 with a start pulse,
// zero-filling (and flagging) any cycle where upstream has no sample.
// Output side frames the last stage's result stream from its start_op pulse.
// Optional build macro: R2SDF_SEQ_STATS_EN adds saturating frame/underrun counters.
module r2sdf_frame_sequencer #(
    parameter int N    = 3,
    parameter int W    = 32,
    parameter int ID_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [W-1:0]    in_re,
    input  logic signed [W-1:0]    in_im,
    output logic signed [W-1:0]    pipe_ip_re,
    output logic signed [W-1:0]    pipe_ip_im,
    output logic                   pipe_start_ip,
    input  logic                   pipe_op_start,
    output logic                   out_valid,
    output logic                   out_last,
    output logic [ID_W-1:0]        out_frame_id,
    output logic                   busy,
    output logic                   underrun,
    output logic                   overlap_err
`ifdef R2SDF_SEQ_STATS_EN
    ,
    output logic [ID_W-1:0]        stat_frames_in,
    output logic [ID_W-1:0]        stat_underruns
`endif
);

    typedef enum logic {IDLE = 1'b0, FEED = 1'b1} state_t;

    // Output count value one before the final sample of a window.
    localparam logic [N-1:0] PRE_LAST = N'((1 << N) - 2);

    state_t         state;
    logic [N-1:0]   in_cnt;
    logic [N-1:0]   out_cnt;
    logic           accept;
    logic           frame_done;
    logic           feed_nxt;
    logic           win_nxt;

    // The pipeline never stalls, so the sequencer is always ready once out of reset.
    assign in_ready   = !reset && (state == IDLE || state == FEED);
    assign accept     = in_valid && in_ready;
    // A new frame may start when idle or when the current frame has just sent its last sample.
    assign frame_done = (state == IDLE) || (in_cnt == '0);
    assign feed_nxt   = accept || !frame_done;
    assign win_nxt    = pipe_op_start || (out_valid && !out_last);

    // Input FSM: start frames, forward one sample per cycle, zero-fill gaps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            in_cnt        <= '0;
            pipe_ip_re    <= '0;
            pipe_ip_im    <= '0;
            pipe_start_ip <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            pipe_start_ip <= 1'b0;
            underrun      <= 1'b0;
            if (frame_done) begin
                if (accept) begin
                    pipe_ip_re    <= in_re;
                    pipe_ip_im    <= in_im;
                    pipe_start_ip <= 1'b1;
                    in_cnt        <= N'(1);
                    state         <= FEED;
                end else begin
                    pipe_ip_re <= '0;
                    pipe_ip_im <= '0;
                    state      <= IDLE;
                end
            end else begin
                in_cnt <= in_cnt + 1'b1;
                if (accept) begin
                    pipe_ip_re <= in_re;
                    pipe_ip_im <= in_im;
                end else begin
                    pipe_ip_re <= '0;
                    pipe_ip_im <= '0;
                    underrun   <= 1'b1;
                end
            end
        end
    end

    // Output window: 2^N valid cycles per start_op, restart on premature start_op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_cnt      <= '0;
            out_frame_id <= '0;
            overlap_err  <= 1'b0;
        end else begin
            overlap_err <= 1'b0;
            if (out_valid && out_last) begin
                out_frame_id <= out_frame_id + 1'b1;
            end
            if (pipe_op_start) begin
                // A start_op on the last sample is a legal back-to-back frame.
                if (out_valid && !out_last) begin
                    overlap_err <= 1'b1;
                end
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                out_cnt   <= '0;
            end else if (out_valid) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    out_cnt   <= '0;
                end else begin
                    out_cnt  <= out_cnt + 1'b1;
                    out_last <= (out_cnt == PRE_LAST);
                end
            end
        end
    end

    // Busy mirrors the next FEED state or next open output window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
        end else begin
            busy <= feed_nxt || win_nxt;
        end
    end

`ifdef R2SDF_SEQ_STATS_EN
    function automatic logic [ID_W-1:0] sat_inc(input logic [ID_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Saturating counts of frame starts and injected zero samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_frames_in <= '0;
            stat_underruns <= '0;
        end else begin
            if (pipe_start_ip) begin
                stat_frames_in <= sat_inc(stat_frames_in);
            end
            if (underrun) begin
                stat_underruns <= sat_inc(stat_underruns);
            end
        end
    end
`endif

endmodule
